// File: rtl/seven_seg_disp.sv
// seven_seg_disp: UART-driven two-digit hex display for a PmodSSD.
// Receives 8N1 bytes, keeps the last valid one, shows it in hex on a
// multiplexed two-digit display and mirrors the low nibble on the LEDs.
module seven_seg_disp #(
    parameter int CLK_FREQ    = 100_000_000,
    parameter int BAUD        = 9600,
    parameter int REFRESH_CNT = 100_000
) (
    input  logic       CLK100MHZ,
    input  logic       ck_rst_n,
    input  logic       uart_rx_of_pmod,
    output logic [3:0] led,
    output logic [3:0] ja,
    output logic [3:0] jb
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CW           = $clog2(CLKS_PER_BIT + 1);
    localparam int RW           = $clog2(REFRESH_CNT + 1);

    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
    localparam logic [RW-1:0] REF_LAST  = RW'(REFRESH_CNT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } rx_state_t;

    logic            rxMeta, rxSync;
    rx_state_t       state, stateNext;
    logic [CW-1:0]   cnt, cntNext;
    logic [2:0]      bitIdx, bitIdxNext;
    logic [7:0]      shift, shiftNext;
    logic            load;
    logic [7:0]      dataReg, dataNext;
    logic [RW-1:0]   refresh;
    logic            refreshWrap;
    logic            digitSel, digitNext;
    logic [3:0]      nibbleNext;
    logic [6:0]      seg, segNext;

    // Hex digit to segment pattern {g,f,e,d,c,b,a}, active high
    function automatic logic [6:0] hexToSeg(input logic [3:0] n);
        case (n)
            4'h0: hexToSeg = 7'h3F;
            4'h1: hexToSeg = 7'h06;
            4'h2: hexToSeg = 7'h5B;
            4'h3: hexToSeg = 7'h4F;
            4'h4: hexToSeg = 7'h66;
            4'h5: hexToSeg = 7'h6D;
            4'h6: hexToSeg = 7'h7D;
            4'h7: hexToSeg = 7'h07;
            4'h8: hexToSeg = 7'h7F;
            4'h9: hexToSeg = 7'h6F;
            4'hA: hexToSeg = 7'h77;
            4'hB: hexToSeg = 7'h7C;
            4'hC: hexToSeg = 7'h39;
            4'hD: hexToSeg = 7'h5E;
            4'hE: hexToSeg = 7'h79;
            default: hexToSeg = 7'h71;
        endcase
    endfunction

    // Two-flop synchroniser for the asynchronous RX line, idles high
    always_ff @(posedge CLK100MHZ or negedge ck_rst_n) begin
        if (!ck_rst_n) begin
            rxMeta <= 1'b1;
            rxSync <= 1'b1;
        end else begin
            rxMeta <= uart_rx_of_pmod;
            rxSync <= rxMeta;
        end
    end

    // Receiver state, baud counter, bit index and shift register
    always_ff @(posedge CLK100MHZ or negedge ck_rst_n) begin
        if (!ck_rst_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            bitIdx <= '0;
            shift  <= '0;
        end else begin
            state  <= stateNext;
            cnt    <= cntNext;
            bitIdx <= bitIdxNext;
            shift  <= shiftNext;
        end
    end

    // Receiver next-state logic; a failed stop bit parks in S_BREAK until the line idles
    always_comb begin
        stateNext  = state;
        cntNext    = cnt + CW'(1);
        bitIdxNext = bitIdx;
        shiftNext  = shift;
        load       = 1'b0;
        case (state)
            S_IDLE: begin
                cntNext = '0;
                if (!rxSync) stateNext = S_START;
            end
            S_START: begin
                if (cnt == HALF_LAST) begin
                    cntNext = '0;
                    if (!rxSync) begin
                        stateNext  = S_DATA;
                        bitIdxNext = '0;
                    end else begin
                        stateNext = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (cnt == BIT_LAST) begin
                    cntNext   = '0;
                    shiftNext = {rxSync, shift[7:1]};
                    if (bitIdx == 3'd7) stateNext = S_STOP;
                    else                bitIdxNext = bitIdx + 3'd1;
                end
            end
            S_STOP: begin
                if (cnt == BIT_LAST) begin
                    cntNext = '0;
                    if (rxSync) begin
                        load      = 1'b1;
                        stateNext = S_IDLE;
                    end else begin
                        stateNext = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                cntNext = '0;
                if (rxSync) stateNext = S_IDLE;
            end
            default: begin
                stateNext = S_IDLE;
                cntNext   = '0;
            end
        endcase
    end

    // Next display values; segments are decoded from next data and next digit
    // so that digit select and pattern always change on the same edge
    always_comb begin
        dataNext    = load ? shift : dataReg;
        refreshWrap = (refresh == REF_LAST);
        digitNext   = digitSel ^ refreshWrap;
        nibbleNext  = digitNext ? dataNext[7:4] : dataNext[3:0];
        segNext     = hexToSeg(nibbleNext);
    end

    // Held byte, LED mirror, refresh counter, digit select and segments
    always_ff @(posedge CLK100MHZ or negedge ck_rst_n) begin
        if (!ck_rst_n) begin
            dataReg  <= 8'h00;
            led      <= 4'h0;
            refresh  <= '0;
            digitSel <= 1'b0;
            seg      <= 7'h3F;
        end else begin
            dataReg  <= dataNext;
            led      <= dataNext[3:0];
            refresh  <= refreshWrap ? '0 : refresh + RW'(1);
            digitSel <= digitNext;
            seg      <= segNext;
        end
    end

    assign ja = seg[3:0];
    assign jb = {digitSel, seg[6:4]};

endmodule

// File: tb/tb_seven_seg_disp.sv
// tb_seven_seg_disp: drives UART frames into seven_seg_disp and checks the
// LEDs and both multiplexed digits against a queue of expected bytes.
module tb_seven_seg_disp;

    localparam int CLK_FREQ    = 1_000_000;
    localparam int BAUD        = 100_000;
    localparam int REFRESH_CNT = 40;
    localparam int CPB         = CLK_FREQ / BAUD;

    typedef struct {
        logic [7:0] txByte;
        logic       stopBit;
        logic [7:0] expData;
    } vector_t;

    logic       clk;
    logic       rstN;
    logic       rx;
    logic [3:0] led;
    logic [3:0] ja;
    logic [3:0] jb;

    int errors;
    int checks;
    logic [7:0] expQ[$];
    logic [6:0] segTab[16];
    vector_t    vecs[9];

    seven_seg_disp #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .REFRESH_CNT(REFRESH_CNT)
    ) dut (
        .CLK100MHZ      (clk),
        .ck_rst_n       (rstN),
        .uart_rx_of_pmod(rx),
        .led            (led),
        .ja             (ja),
        .jb             (jb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkEq(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Serial frame: start bit, 8 data bits LSB first, stop bit, then idle high
    task automatic sendByte(input logic [7:0] b, input logic stopBit);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stopBit;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic applyStimulus(input logic [7:0] b, input logic stopBit, input logic [7:0] expData);
        expQ.push_back(expData);
        sendByte(b, stopBit);
    endtask

    // Wait (bounded) until the digit select reaches the wanted value
    task automatic waitDigit(input logic want, output logic ok);
        ok = 1'b0;
        for (int n = 0; n < 3 * REFRESH_CNT; n++) begin
            @(negedge clk);
            if (jb[3] === want) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [7:0] exp;
        logic ok;
        repeat (4) @(negedge clk);
        if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s scoreboard: got empty queue, expected an entry", tag);
            return;
        end
        exp = expQ.pop_front();
        checkEq({tag, " led"}, {4'h0, led}, {4'h0, exp[3:0]});
        waitDigit(1'b0, ok);
        if (!ok) checkEq({tag, " right-digit timeout"}, {7'h0, jb[3]}, 8'h00);
        else     checkEq({tag, " right seg"}, {1'b0, jb[2:0], ja}, {1'b0, segTab[exp[3:0]]});
        waitDigit(1'b1, ok);
        if (!ok) checkEq({tag, " left-digit timeout"}, {7'h0, jb[3]}, 8'h01);
        else     checkEq({tag, " left seg"}, {1'b0, jb[2:0], ja}, {1'b0, segTab[exp[7:4]]});
    endtask

    initial begin
        int n;
        logic ok;
        errors = 0;
        checks = 0;
        segTab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                   7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        vecs = '{
            '{8'h35, 1'b1, 8'h35},
            '{8'hA7, 1'b0, 8'h35},
            '{8'hA7, 1'b1, 8'hA7},
            '{8'h89, 1'b1, 8'h89},
            '{8'hBC, 1'b1, 8'hBC},
            '{8'hD6, 1'b0, 8'hBC},
            '{8'hD6, 1'b1, 8'hD6},
            '{8'h4E, 1'b1, 8'h4E},
            '{8'h01, 1'b1, 8'h01}
        };

        rx   = 1'b1;
        rstN = 1'b0;
        repeat (3) @(negedge clk);
        checkEq("reset led", {4'h0, led}, 8'h00);
        checkEq("reset seg", {1'b0, jb[2:0], ja}, 8'h3F);
        checkEq("reset digit select", {7'h0, jb[3]}, 8'h00);
        rstN = 1'b1;

        // Refresh period: a full phase of the digit select lasts REFRESH_CNT clocks
        waitDigit(1'b1, ok);
        n = 0;
        if (ok) begin
            for (int i = 0; i < 5 * REFRESH_CNT; i++) begin
                @(negedge clk);
                n++;
                if (jb[3] === 1'b0) break;
            end
        end
        checkEq("refresh period", 8'(n), 8'(REFRESH_CNT));

        expQ.push_back(8'h00);
        checkOutput("idle 00");

        for (int v = 0; v < 9; v++) begin
            applyStimulus(vecs[v].txByte, vecs[v].stopBit, vecs[v].expData);
            repeat (3) @(negedge clk);
            checkOutput($sformatf("vec%0d", v));
        end

        // False start: a short low pulse must not disturb the held byte
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        expQ.push_back(8'h01);
        checkOutput("false start");

        // Reset in the middle of a frame restores reset values at once
        applyStimulus(8'h5A, 1'b1, 8'h5A);
        checkOutput("pre-reset");
        rx = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        rstN = 1'b0;
        #1;
        checkEq("midframe reset led", {4'h0, led}, 8'h00);
        checkEq("midframe reset seg", {1'b0, jb[2:0], ja}, 8'h3F);
        checkEq("midframe reset digit", {7'h0, jb[3]}, 8'h00);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rstN = 1'b1;
        repeat (2) @(negedge clk);
        applyStimulus(8'h0F, 1'b1, 8'h0F);
        checkOutput("after reset 0F");

        // Back-to-back frames with a single stop bit each
        sendByte(8'h12, 1'b1);
        applyStimulus(8'hFE, 1'b1, 8'hFE);
        checkOutput("back-to-back FE");

        checkEq("scoreboard drained", 8'(expQ.size()), 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
